// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the single-clock FWFT FIFO.
package sync_fifo_pkg;

  // Pointers and occupancy carry one extra bit so that a full FIFO is distinct from an empty one.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned default_af_level(input int unsigned addr_width);
    if (addr_width < 2) begin
      return 1 << addr_width;
    end
    return (1 << addr_width) - 2;
  endfunction

  localparam int unsigned DefaultAeLevel = 2;

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Request/response bundle between a FIFO user (master) and sync_fifo_fwft (slave).
interface sync_fifo_fwft_if #(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned ADDR_WIDTH = 4
);
  import sync_fifo_pkg::*;

  localparam int unsigned PtrW = ptr_width(ADDR_WIDTH);

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PtrW-1:0]       count;
  logic                  overflow;
  logic                  underflow;
  logic [PtrW-1:0]       peak_level;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow,
           peak_level
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow,
           peak_level
  );

endinterface

// File: rtl/strobe_edge_detect.sv
// Request qualifier: passes a level request through, or turns it into a one-cycle rising-edge pulse.
module strobe_edge_detect #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic req
);

  logic en_q;

  // Tracks en every cycle regardless of FIFO state, so a held request never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en;
    end
  end

  assign req = EDGE ? (en & ~en_q) : en;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with fill level, thresholds and sticky error flags.
// Define SYNC_FIFO_PEAK_EN to build the peak_level high-water register; otherwise it reads 0.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 35,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter bit          EDGE_STROBE = 1'b1,
  parameter int unsigned AF_LEVEL    = default_af_level(ADDR_WIDTH),
  parameter int unsigned AE_LEVEL    = DefaultAeLevel
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_fwft_if.slave bus
);

  localparam int unsigned PtrW  = ptr_width(ADDR_WIDTH);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  localparam logic [PtrW-1:0] AfLvl = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLvl = PtrW'(AE_LEVEL);
  localparam logic [PtrW-1:0] One   = PtrW'(1);

  logic wr_req;
  logic rd_req;

  strobe_edge_detect #(
    .EDGE (EDGE_STROBE)
  ) u_wr_strobe (
    .clk (clk),
    .rst (rst),
    .en  (bus.wr_en),
    .req (wr_req)
  );

  strobe_edge_detect #(
    .EDGE (EDGE_STROBE)
  ) u_rd_strobe (
    .clk (clk),
    .rst (rst),
    .en  (bus.rd_en),
    .req (rd_req)
  );

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full is judged before any same-cycle pop, so a write into a full FIFO is always dropped.
  assign wr_acc = wr_req & ~full & ~bus.clear;
  assign rd_acc = rd_req & ~empty & ~bus.clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + One;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + One;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + One;
        2'b01:   count_d = count_q - One;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (wr_req & full);
      underflow_d = underflow_q | (rd_req & empty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never reset or flushed; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  logic [PtrW-1:0] peak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (bus.clear) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end

  assign bus.peak_level = peak_q;
`else
  assign bus.peak_level = '0;
`endif

  assign bus.rd_data      = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign bus.rd_valid     = ~empty;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AfLvl);
  assign bus.almost_empty = (count_q <= AeLvl);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Single-clock, parametrised first-word-fall-through FIFO. It replaces the dual-clock pointer FIFO in the picture-frame datapath (pixel/command buffering between the SD/SDRAM loaders and the VGA fetch logic) wherever both sides share one clock. Improvements over the previous generation:
- Full depth is usable, via an extra pointer wrap bit.
- Selectable level or edge strobe mode.
- Fill count, almost-full/almost-empty thresholds, and sticky overflow/underflow flags.

Parameters:
DATA_WIDTH, 35, width of each stored word
ADDR_WIDTH, 4, log2 of depth; depth = 2**ADDR_WIDTH, all entries usable
EDGE_STROBE, 1, 1 = accept one request per rising edge of wr_en/rd_en; 0 = accept every cycle the request is high
AF_LEVEL, 2**ADDR_WIDTH-2, almost_full threshold (count >= AF_LEVEL)
AE_LEVEL, 2, almost_empty threshold (count <= AE_LEVEL)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous flush
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request (pops head)
rd_data  out  DATA_WIDTH  head word; valid while rd_valid=1
rd_valid  out  1  equals !empty
full  out  1  count == 2**ADDR_WIDTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy
overflow  out  1  sticky: write requested while full
underflow  out  1  sticky: read requested while empty
peak_level  out  ADDR_WIDTH+1  high-water mark (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0, peak_level=0, edge registers=0. Outputs during reset: empty=1, rd_valid=0, full=0, almost_empty=1, almost_full=0.
- Pointers: ADDR_WIDTH+1 bits. Memory is indexed by the low ADDR_WIDTH bits.
  - full: MSBs differ and low bits equal.
  - empty: pointers equal.
  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- Request qualification:
  - EDGE_STROBE=1: wr_req = wr_en & !wr_en_q. rd_req is formed the same way from rd_en.
  - EDGE_STROBE=0: wr_req = wr_en and rd_req = rd_en.
  - wr_en_q and rd_en_q update every cycle, including during clear.
- Write accept = wr_req & !full. On accept: mem[wr_ptr] <= wr_data and wr_ptr+1.
- Read accept = rd_req & !empty. On accept: rd_ptr+1.
- rd_data is a combinational read of mem[rd_ptr]. Latency is zero: a word written in cycle N appears on rd_data in cycle N+1.
- Simultaneous write and read accept: both happen and count is unchanged.
- Write while full is rejected even if a read is accepted in the same cycle. The data is dropped, overflow is set, and the edge is consumed (no retry).
- Read while empty: no pointer change, underflow is set.
- count: registered, +1/-1/0 according to the accepts. It never exceeds 2**ADDR_WIDTH and never goes below 0.
- almost_full and almost_empty are combinational from count.
- clear has priority over any same-cycle wr/rd. It zeroes both pointers, count, overflow, underflow and peak_level. Memory contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately. A request held high across reset release is seen as an edge in the first cycle after release (EDGE_STROBE=1).

Optional Feature:
Macro SYNC_FIFO_PEAK_EN.
- Defined: peak_level is a register. It loads count_next when count_next > peak_level, and is zeroed by rst and clear.
- Not defined: peak_level is tied to 0 and no register is inferred.

Decomposition:
- Package sync_fifo_pkg holds:
  - a function computing default thresholds from ADDR_WIDTH;
  - a typedef-equivalent width constant helper for count/pointer (ADDR_WIDTH+1).
- One natural sub-module, strobe_edge_detect: a parametrised mode, with a registered previous value and a req output. It is instantiated twice, for wr and rd.

Test Plan:
- Reset, then EDGE_STROBE=0, ADDR_WIDTH=2: write 4 words 0xA..0xD back-to-back -> full=1, count=4, almost_full=1; a 5th write -> overflow=1, count stays 4.
- Drain 4 reads -> rd_data sequence 0xA,0xB,0xC,0xD, then empty=1; a further read -> underflow=1.
- EDGE_STROBE=1: wr_en held high 5 cycles with data 0x55 -> exactly one write, count=1.
- Full FIFO with simultaneous wr+rd -> read pops, write rejected, overflow=1, count=3. Half-full FIFO with simultaneous wr+rd -> count unchanged and ordering preserved.
- 3 words present, assert clear with wr_en=1 -> count=0, empty=1, flags=0, write ignored. Async rst pulse mid-burst -> all outputs at reset values within the same cycle.
- With SYNC_FIFO_PEAK_EN: fill to 3, drain to 1 -> peak_level=3; after clear -> 0. Without the macro -> peak_level always 0.
